// File: rtl/sht40_unit_convert.sv
// ---------------------------------------------------------------------------
// sht40_unit_convert
//
// Converts the SHT40 decoder's raw 16-bit temperature and humidity words into
// signed hundredths of degC and hundredths of %RH:
//     result = floor(SCALE * raw / 65536) - OFFSET
// A single shift-add multiplier (one multiplier bit per clock) is shared by
// both channels, so no hardware multiplier is inferred.
//
// A rising edge on a ready level captures that channel's raw word into a hold
// register and marks it pending. The FSM (IDLE -> MUL -> DONE) converts one
// pending channel at a time, temperature first when both are pending.
// A conversion takes 18 clocks from the capture edge to the valid strobe.
//
// Optional build macro:
//   SHT40_RH_CLAMP_EN  - saturate the humidity result to 0..10000 (0..100 %RH).
//                        Without it rh_centi carries the raw signed result.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_temp_raw    raw temperature word from decoder
//   i_rh_raw      raw humidity word from decoder
//   i_temp_ready  decoder temperature-ready level
//   i_rh_ready    decoder humidity-ready level
//   o_temp_centi  signed temperature, 0.01 degC/LSB
//   o_rh_centi    signed humidity, 0.01 %RH/LSB
//   o_temp_valid  one-cycle strobe, o_temp_centi updated
//   o_rh_valid    one-cycle strobe, o_rh_centi updated
//   o_busy        high while a conversion is in flight
//   o_overrun     sticky {rh, temp}: a new sample replaced an unconverted one
// ---------------------------------------------------------------------------
module sht40_unit_convert #(
    parameter int TEMP_SCALE  = 17500,
    parameter int TEMP_OFFSET = 4500,
    parameter int RH_SCALE    = 12500,
    parameter int RH_OFFSET   = 600
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_temp_raw,
    input  logic [15:0] i_rh_raw,
    input  logic        i_temp_ready,
    input  logic        i_rh_ready,
    output logic [15:0] o_temp_centi,
    output logic [15:0] o_rh_centi,
    output logic        o_temp_valid,
    output logic        o_rh_valid,
    output logic        o_busy,
    output logic [1:0]  o_overrun
);

    localparam logic [31:0] TEMP_SCALE_W  = 32'(TEMP_SCALE);
    localparam logic [31:0] RH_SCALE_W    = 32'(RH_SCALE);
    localparam logic [15:0] TEMP_OFFSET_W = 16'(TEMP_OFFSET);
    localparam logic [15:0] RH_OFFSET_W   = 16'(RH_OFFSET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Ready edge detection; previous sample resets to 0 so a level that is
    // already high when reset drops is treated as a fresh sample.
    logic        r_temp_rdy_d;
    logic        r_rh_rdy_d;
    logic        w_temp_cap;
    logic        w_rh_cap;

    // Capture side
    logic [15:0] r_temp_hold;
    logic [15:0] r_rh_hold;
    logic        r_temp_pend;
    logic        r_rh_pend;
    logic [1:0]  r_overrun;

    // Shared shift-add multiplier
    logic        r_sel_rh;      // channel being converted: 0 = temp, 1 = rh
    logic [31:0] r_mcand;
    logic [15:0] r_mplier;
    logic [31:0] r_acc;
    logic [3:0]  r_cnt;

    // Start/finish decode
    logic        w_start;
    logic        w_start_temp;
    logic        w_start_rh;

    // Result path
    logic [15:0] w_prod_hi;
    logic [15:0] w_result;
    logic [15:0] w_rh_result;

    // Output registers
    logic [15:0] r_temp_centi;
    logic [15:0] r_rh_centi;
    logic        r_temp_valid;
    logic        r_rh_valid;

    assign w_temp_cap   = i_temp_ready & ~r_temp_rdy_d;
    assign w_rh_cap     = i_rh_ready   & ~r_rh_rdy_d;

    assign w_start      = (r_state == IDLE) && (r_temp_pend || r_rh_pend);
    assign w_start_temp = w_start &  r_temp_pend;
    assign w_start_rh   = w_start & ~r_temp_pend;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = MUL;
                end
            end
            MUL: begin
                // 16 multiply steps; the step with counter 15 is the last.
                if (r_cnt == 4'd15) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ready edge detect, hold registers, pending flags, overrun
    // ------------------------------------------------------------------
    // A capture that coincides with the start of the same channel re-arms
    // pending with the new word; that is not an overrun because the old word
    // is being consumed on this very edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_temp_rdy_d <= 1'b0;
            r_rh_rdy_d   <= 1'b0;
            r_temp_hold  <= 16'd0;
            r_rh_hold    <= 16'd0;
            r_temp_pend  <= 1'b0;
            r_rh_pend    <= 1'b0;
            r_overrun    <= 2'b00;
        end else begin
            r_temp_rdy_d <= i_temp_ready;
            r_rh_rdy_d   <= i_rh_ready;

            if (w_temp_cap) begin
                r_temp_hold <= i_temp_raw;
                r_temp_pend <= 1'b1;
                if (r_temp_pend && !w_start_temp) begin
                    r_overrun[0] <= 1'b1;
                end
            end else if (w_start_temp) begin
                r_temp_pend <= 1'b0;
            end

            if (w_rh_cap) begin
                r_rh_hold <= i_rh_raw;
                r_rh_pend <= 1'b1;
                if (r_rh_pend && !w_start_rh) begin
                    r_overrun[1] <= 1'b1;
                end
            end else if (w_start_rh) begin
                r_rh_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier: acc accumulates SCALE * raw, LSB first.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_rh <= 1'b0;
            r_mcand  <= 32'd0;
            r_mplier <= 16'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 4'd0;
        end else if (w_start) begin
            r_sel_rh <= w_start_rh;
            r_mcand  <= w_start_rh ? RH_SCALE_W : TEMP_SCALE_W;
            r_mplier <= w_start_rh ? r_rh_hold  : r_temp_hold;
            r_acc    <= 32'd0;
            r_cnt    <= 4'd0;
        end else if (r_state == MUL) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result: upper product half minus offset. Only the low 16 bits of the
    // 17-bit difference are kept, so 16-bit modular subtraction gives the
    // same bits.
    // ------------------------------------------------------------------
    assign w_prod_hi = r_acc[31:16];
    assign w_result  = w_prod_hi - (r_sel_rh ? RH_OFFSET_W : TEMP_OFFSET_W);

`ifdef SHT40_RH_CLAMP_EN
    // Unclamped humidity spans -600..11899, which fits a signed 16-bit
    // compare without wrap.
    always_comb begin
        w_rh_result = w_result;
        if ($signed(w_result) < 16'sd0) begin
            w_rh_result = 16'd0;
        end else if ($signed(w_result) > 16'sd10000) begin
            w_rh_result = 16'd10000;
        end
    end
`else
    assign w_rh_result = w_result;
`endif

    // ------------------------------------------------------------------
    // Output registers and valid strobes
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_temp_centi <= 16'd0;
            r_rh_centi   <= 16'd0;
            r_temp_valid <= 1'b0;
            r_rh_valid   <= 1'b0;
        end else begin
            r_temp_valid <= 1'b0;
            r_rh_valid   <= 1'b0;
            if (r_state == DONE) begin
                if (r_sel_rh) begin
                    r_rh_centi <= w_rh_result;
                    r_rh_valid <= 1'b1;
                end else begin
                    r_temp_centi <= w_result;
                    r_temp_valid <= 1'b1;
                end
            end
        end
    end

    assign o_temp_centi = r_temp_centi;
    assign o_rh_centi   = r_rh_centi;
    assign o_temp_valid = r_temp_valid;
    assign o_rh_valid   = r_rh_valid;
    assign o_busy       = (r_state != IDLE);
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_sht40_unit_convert.sv
// Scoreboard bench for sht40_unit_convert. Expected results are queued when
// a ready edge is driven and checked when the matching valid strobe appears.
module tb_sht40_unit_convert;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] temp_raw = 16'd0;
    logic [15:0] rh_raw = 16'd0;
    logic        temp_ready = 1'b0;
    logic        rh_ready = 1'b0;
    logic [15:0] temp_centi;
    logic [15:0] rh_centi;
    logic        temp_valid;
    logic        rh_valid;
    logic        busy;
    logic [1:0]  overrun;

`ifdef SHT40_RH_CLAMP_EN
    localparam logic [15:0] RH_AT_FFFF = 16'd10000;
    localparam logic [15:0] RH_AT_0000 = 16'd0;
`else
    localparam logic [15:0] RH_AT_FFFF = 16'd11899;
    localparam logic [15:0] RH_AT_0000 = 16'hFDA8;
`endif

    sht40_unit_convert dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_temp_raw   (temp_raw),
        .i_rh_raw     (rh_raw),
        .i_temp_ready (temp_ready),
        .i_rh_ready   (rh_ready),
        .o_temp_centi (temp_centi),
        .o_rh_centi   (rh_centi),
        .o_temp_valid (temp_valid),
        .o_rh_valid   (rh_valid),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h (%0d) exp=0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic [15:0] val;
        int          cyc;   // negedge cycle the valid must appear on, -1 = any
    } exp_t;

    exp_t tq[$];
    exp_t rq[$];

    // Output monitor
    exp_t te;
    exp_t re;
    always @(negedge clk) begin
        if (temp_valid === 1'b1) begin
            if (tq.size() == 0) begin
                chk("temp_spurious_valid", 32'd1, 32'd0);
            end else begin
                te = tq.pop_front();
                chk("temp_centi", {16'd0, temp_centi}, {16'd0, te.val});
                if (te.cyc >= 0) chk("temp_latency", cyc, te.cyc);
            end
        end
        if (rh_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("rh_spurious_valid", 32'd1, 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rh_centi", {16'd0, rh_centi}, {16'd0, re.val});
                if (re.cyc >= 0) chk("rh_latency", cyc, re.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the following posedge is the capture edge.
    task automatic pulse_temp(input logic [15:0] raw, input logic [15:0] exp,
                              input int lat, input bit push);
        exp_t e;
        e.val = exp;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        temp_raw   = raw;
        temp_ready = 1'b1;
        if (push) tq.push_back(e);
        @(negedge clk);
        temp_ready = 1'b0;
    endtask

    task automatic pulse_rh(input logic [15:0] raw, input logic [15:0] exp,
                            input int lat, input bit push);
        exp_t e;
        e.val = exp;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        rh_raw   = raw;
        rh_ready = 1'b1;
        if (push) rq.push_back(e);
        @(negedge clk);
        rh_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((tq.size() != 0 || rq.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("wait_idle_timeout", 32'd1, 32'd0);
        tick(2);
    endtask

    initial begin
        int n0;
        exp_t et;
        exp_t er;

        // Reset state
        tick(3);
        chk("rst_temp_centi", {16'd0, temp_centi}, 32'd0);
        chk("rst_rh_centi",   {16'd0, rh_centi},   32'd0);
        chk("rst_temp_valid", {31'd0, temp_valid}, 32'd0);
        chk("rst_rh_valid",   {31'd0, rh_valid},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_overrun",    {30'd0, overrun},    32'd0);
        rst = 1'b0;
        tick(2);

        // Basic temperature conversions
        pulse_temp(16'h6666, 16'd2499, 19, 1'b1);
        wait_idle();
        pulse_temp(16'h0000, 16'hEE6C, 19, 1'b1);
        wait_idle();
        pulse_temp(16'hFFFF, 16'd12999, 19, 1'b1);
        wait_idle();
        tick(5);
        chk("temp_hold", {16'd0, temp_centi}, 32'd12999);

        // Humidity conversions including range ends
        pulse_rh(16'h8000, 16'd5650, 19, 1'b1);
        wait_idle();
        pulse_rh(16'hFFFF, RH_AT_FFFF, 19, 1'b1);
        wait_idle();
        pulse_rh(16'h0000, RH_AT_0000, 19, 1'b1);
        wait_idle();
        chk("temp_hold_after_rh", {16'd0, temp_centi}, 32'd12999);

        // Both ready on the same edge: temperature first, rh right after
        n0 = cyc;
        temp_raw = 16'h6666;
        rh_raw   = 16'h8000;
        temp_ready = 1'b1;
        rh_ready   = 1'b1;
        et.val = 16'd2499; et.cyc = n0 + 19;
        er.val = 16'd5650; er.cyc = n0 + 37;
        tq.push_back(et);
        rq.push_back(er);
        @(negedge clk);
        temp_ready = 1'b0;
        rh_ready   = 1'b0;
        tick(n0 + 18 - cyc);
        chk("both_busy_done", {31'd0, busy}, 32'd1);
        tick(1);
        chk("both_busy_gap", {31'd0, busy}, 32'd0);
        tick(1);
        chk("both_busy_rh", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("no_overrun_yet", {30'd0, overrun}, 32'd0);

        // Two rh samples while temperature is converting -> rh overrun
        pulse_temp(16'h6666, 16'd2499, 19, 1'b1);
        tick(3);
        pulse_rh(16'h4000, 16'd0, -1, 1'b0);
        tick(2);
        pulse_rh(16'h8000, 16'd5650, -1, 1'b1);
        chk("overrun_set", {30'd0, overrun}, 32'd2);
        chk("overrun_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        tick(20);
        chk("overrun_sticky", {30'd0, overrun}, 32'd2);

        // Reset at Es+8 of a conversion
        n0 = cyc;
        pulse_temp(16'h0000, 16'd0, -1, 1'b0);
        tick(n0 + 9 - cyc);
        rst = 1'b1;
        tick(1);
        chk("midrst_busy",       {31'd0, busy},       32'd0);
        chk("midrst_overrun",    {30'd0, overrun},    32'd0);
        chk("midrst_temp_centi", {16'd0, temp_centi}, 32'd0);
        chk("midrst_rh_centi",   {16'd0, rh_centi},   32'd0);
        chk("midrst_temp_valid", {31'd0, temp_valid}, 32'd0);
        rst = 1'b0;
        tick(30);

        // Conversions after reset
        pulse_rh(16'h8000, 16'd5650, 19, 1'b1);
        wait_idle();
        pulse_temp(16'hFFFF, 16'd12999, 19, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
